// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the multi-channel line memory port: default sizes,
// line geometry and the request record.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif

package mem_pkg;
    localparam int DEF_WORD_SIZE = `WORD_SIZE;
    localparam int DEF_LINE_SIZE = `CACHE_LINE_SIZE;
    localparam int DEF_MEM_SIZE  = `MEM_SIZE;

    localparam int OFF       = $clog2(DEF_LINE_SIZE / 8);
    localparam int NUM_LINES = DEF_MEM_SIZE * 8 / DEF_LINE_SIZE;
    localparam int IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef struct packed {
        logic                     write;
        logic [DEF_WORD_SIZE-1:0] addr;
        logic [DEF_LINE_SIZE-1:0] wdata;
    } mem_req_t;

    // Geometry helpers so parametrised instances derive their own widths.
    function automatic int line_off(input int line_size);
        return $clog2(line_size / 8);
    endfunction

    function automatic int idx_width(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the per-channel request/response buses between cache miss ports
// (master) and the shared memory arbiter (slave).
interface mem_port_if
    import mem_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int LINE_SIZE = DEF_LINE_SIZE
);
    logic [N_CH-1:0]           req_valid;
    logic [N_CH-1:0]           req_write;
    logic [N_CH*WORD_SIZE-1:0] req_addr;
    logic [N_CH*LINE_SIZE-1:0] req_wdata;
    logic [N_CH-1:0]           req_ready;
    logic [N_CH-1:0]           res_valid;
    logic [N_CH*WORD_SIZE-1:0] res_addr;
    logic [N_CH*LINE_SIZE-1:0] res_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, res_valid, res_addr, res_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, res_valid, res_addr, res_data
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: grants the first pending requester at or after
// the pointer, wrapping, and reports the grant one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);
    logic [PW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// N request channels sharing one single-ported line-wide store: round-robin
// issue, fixed-latency pipeline and per-channel tagged response pulses.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int LATENCY   = 3
) (
    input logic       clk,
    input logic       rst,
    mem_port_if.slave bus
);
    localparam int LOFF  = line_off(LINE_SIZE);
    localparam int LINES = MEM_SIZE * 8 / LINE_SIZE;
    localparam int IW    = idx_width(LINES);
    localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]      pending, busy, accept, grant, fin_mask;
    logic [PW-1:0]        gidx, rr_ptr, fin_ch;
    logic                 gvalid, fin_valid;

    logic                 s_write [N_CH];
    logic [WORD_SIZE-1:0] s_addr  [N_CH];
    logic [LINE_SIZE-1:0] s_wdata [N_CH];
    logic [LINE_SIZE-1:0] mem     [LINES];

    logic                 iss_write;
    logic [WORD_SIZE-1:0] iss_addr, iss_line;
    logic [IW-1:0]        iss_idx;

    logic                 p_valid [LATENCY];
    logic [PW-1:0]        p_ch    [LATENCY];
    logic                 p_write [LATENCY];
    logic [WORD_SIZE-1:0] p_addr  [LATENCY];
    logic [LINE_SIZE-1:0] p_data  [LATENCY];

    logic [N_CH-1:0]           res_valid;
    logic [N_CH*WORD_SIZE-1:0] res_addr;
    logic [N_CH*LINE_SIZE-1:0] res_data;

    assign accept        = bus.req_valid & ~busy;
    assign bus.req_ready = ~busy;

    rr_arbiter #(.N(N_CH), .PW(PW)) u_rr (
        .pending    (pending),
        .ptr        (rr_ptr),
        .grant      (grant),
        .grant_idx  (gidx),
        .grant_valid(gvalid)
    );

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (accept[c]) begin
                s_write[c] <= bus.req_write[c];
                s_addr[c]  <= bus.req_addr[c*WORD_SIZE +: WORD_SIZE];
                s_wdata[c] <= bus.req_wdata[c*LINE_SIZE +: LINE_SIZE];
            end
        end
    end

    // Out-of-range addresses wrap onto the array by line index.
    assign iss_write = s_write[gidx];
    assign iss_addr  = s_addr[gidx];
    assign iss_idx   = IW'((iss_addr >> LOFF) % WORD_SIZE'(LINES));
    assign iss_line  = iss_addr & ~WORD_SIZE'(LINE_SIZE / 8 - 1);

    always_ff @(posedge clk) begin
        if (gvalid && iss_write)
            mem[iss_idx] <= s_wdata[gidx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                p_valid[i] <= 1'b0;
                p_ch[i]    <= '0;
            end
        end else begin
            p_valid[0] <= gvalid;
            p_ch[0]    <= gidx;
            for (int i = 1; i < LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_ch[i]    <= p_ch[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        p_write[0] <= iss_write;
        p_addr[0]  <= iss_line;
        p_data[0]  <= mem[iss_idx];
        for (int i = 1; i < LATENCY; i++) begin
            p_write[i] <= p_write[i-1];
            p_addr[i]  <= p_addr[i-1];
            p_data[i]  <= p_data[i-1];
        end
    end

    // The entry about to reach the output stage frees its channel on that edge.
    generate
        if (LATENCY == 1) begin : g_fin_issue
            assign fin_valid = gvalid;
            assign fin_ch    = gidx;
        end else begin : g_fin_pipe
            assign fin_valid = p_valid[LATENCY-2];
            assign fin_ch    = p_ch[LATENCY-2];
        end
    endgenerate

    always_comb begin
        fin_mask = '0;
        if (fin_valid)
            fin_mask[fin_ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            busy    <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending | accept) & ~grant;
            busy    <= (busy | accept) & ~fin_mask;
            if (gvalid)
                rr_ptr <= (gidx == PW'(N_CH - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_comb begin
        res_valid = '0;
        res_addr  = '0;
        res_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (p_valid[LATENCY-1] && p_ch[LATENCY-1] == PW'(c)) begin
                res_valid[c]                       = 1'b1;
                res_addr[c*WORD_SIZE +: WORD_SIZE] = p_addr[LATENCY-1];
                res_data[c*LINE_SIZE +: LINE_SIZE] = p_write[LATENCY-1] ? '0 : p_data[LATENCY-1];
            end
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_addr  = res_addr;
    assign bus.res_data  = res_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with three channels, 128-bit lines,
// a 4 KiB store and three-cycle latency.
module tb_mem_port_arbiter;
    localparam int N    = 3;
    localparam int W    = 32;
    localparam int L    = 128;
    localparam int MSZ  = 4096;
    localparam int LAT  = 3;

    typedef struct {
        int           ch;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic rst;
    exp_t expq[$];
    int   errors;
    int   checks;
    int   resp_count;

    mem_port_if #(.N_CH(N), .WORD_SIZE(W), .LINE_SIZE(L)) bus ();

    mem_port_arbiter #(
        .N_CH(N), .WORD_SIZE(W), .LINE_SIZE(L), .MEM_SIZE(MSZ), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Response monitor: pops the scoreboard whenever any channel pulses.
    always @(negedge clk) begin
        if (!rst && (|bus.res_valid)) begin
            int   ch;
            exp_t e;
            ch = 0;
            for (int i = N - 1; i >= 0; i--)
                if (bus.res_valid[i]) ch = i;
            resp_count++;
            checkOutput("res_onehot", 128'($countones(bus.res_valid)), 128'd1);
            if (expq.size() == 0) begin
                checkOutput("unexpected_response_ch", 128'(ch), 128'hFFFF);
            end else begin
                e = expq.pop_front();
                checkOutput("res_ch", 128'(ch), 128'(e.ch));
                checkOutput("res_addr", 128'(bus.res_addr[ch*W +: W]), 128'(e.addr));
                checkOutput("res_data", bus.res_data[ch*L +: L], e.data);
                for (int i = 0; i < N; i++)
                    if (i != ch)
                        checkOutput("idle_ch_zero",
                            128'(bus.res_addr[i*W +: W]) | bus.res_data[i*L +: L], 128'd0);
            end
        end
    end

    task automatic applyStimulus(input int ch, input logic wr, input logic [31:0] addr,
                                 input logic [127:0] wdata, input logic [127:0] exp_data);
        int n;
        exp_t e;
        bus.req_valid[ch]          = 1'b1;
        bus.req_write[ch]          = wr;
        bus.req_addr[ch*W +: W]    = addr;
        bus.req_wdata[ch*L +: L]   = wdata;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[ch] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 128'(n), 128'd0);
        e.ch = ch; e.addr = addr & 32'hFFFF_FFF0; e.data = exp_data;
        expq.push_back(e);
        @(posedge clk);
        #1 bus.req_valid[ch] = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expq.size() != 0 || bus.req_ready !== 3'b111) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 128'(expq.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  c_addr [N];
    logic [127:0] c_data [N];

    // All three channels request together; responses come on consecutive cycles.
    task automatic contend(input int first);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.ch = (first + k) % N; e.addr = c_addr[e.ch]; e.data = c_data[e.ch];
            expq.push_back(e);
        end
        for (int c = 0; c < N; c++) begin
            bus.req_valid[c]       = 1'b1;
            bus.req_write[c]       = 1'b0;
            bus.req_addr[c*W +: W] = c_addr[c];
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        for (int k = 0; k < LAT; k++) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checkOutput("contend_order", 128'(bus.res_valid), 128'(3'b001 << ((first + k) % N)));
        end
        waitIdle();
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] l2;
        int n;
        int saved;
        errors = 0; checks = 0; resp_count = 0;
        a5 = {16{8'hA5}};
        l2 = {16{8'h22}};
        c_addr[0] = 32'h50;  c_data[0] = a5;
        c_addr[1] = 32'h100; c_data[1] = 128'h1234;
        c_addr[2] = 32'h20;  c_data[2] = l2;
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 128'(bus.req_ready), 128'(3'b111));
        checkOutput("reset_res_valid", 128'(bus.res_valid), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1, 1'b1, 32'h50, a5, 128'd0);
        waitIdle();
        applyStimulus(2, 1'b1, 32'h20, l2, 128'd0);
        waitIdle();

        // Unloaded read timing: accepted end of cycle 0, response in cycle 4.
        begin
            exp_t e;
            e.ch = 0; e.addr = 32'h50; e.data = a5;
            bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b0; bus.req_addr[0 +: W] = 32'h50;
            @(negedge clk);
            checkOutput("ready_cycle0", 128'(bus.req_ready[0]), 128'd1);
            expq.push_back(e);
            @(posedge clk);
            #1 bus.req_valid[0] = 1'b0;
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                checkOutput("busy_ready_low", 128'(bus.req_ready[0]), 128'd0);
                checkOutput("no_early_res", 128'(bus.res_valid[0]), 128'd0);
            end
            @(negedge clk);
            checkOutput("res_cycle4", 128'(bus.res_valid[0]), 128'd1);
            checkOutput("ready_in_res_cycle", 128'(bus.req_ready[0]), 128'd1);
            waitIdle();
        end

        applyStimulus(1, 1'b1, 32'h104, 128'h1234, 128'd0);
        waitIdle();
        applyStimulus(1, 1'b0, 32'h100, '0, 128'h1234);
        waitIdle();

        applyStimulus(2, 1'b0, 32'h20, '0, l2);
        waitIdle();
        contend(0);
        contend(0);
        applyStimulus(0, 1'b0, 32'h50, '0, a5);
        waitIdle();
        contend(1);

        applyStimulus(0, 1'b0, MSZ + 32'h20, '0, l2);
        waitIdle();

        // Reset two cycles after issue drops the request silently.
        bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b0; bus.req_addr[0 +: W] = 32'h50;
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        saved = resp_count;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_during_reset", 128'(bus.req_ready), 128'(3'b111));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("dropped_no_response", 128'(resp_count - saved), 128'd0);
        checkOutput("ready_after_reset", 128'(bus.req_ready), 128'(3'b111));
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'h100, '0, 128'h1234);
        waitIdle();

        // Back-to-back: re-request in the response cycle.
        applyStimulus(0, 1'b0, 32'h50, '0, a5);
        n = 0;
        while (!bus.res_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_first_seen", 128'(bus.res_valid[0]), 128'd1);
        begin
            exp_t e;
            e.ch = 0; e.addr = 32'h20; e.data = l2;
            expq.push_back(e);
        end
        bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b0; bus.req_addr[0 +: W] = 32'h20;
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid[0] && n < 20);
        checkOutput("b2b_spacing", 128'(n), 128'(LAT + 1));
        waitIdle();

        checkOutput("scoreboard_empty", 128'(expq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
